// File: rtl/aes_pkg.sv
// Shared AES definitions for the round datapath: state width, GF(2^8) helpers and
// the MixColumns sequencer state encoding.
package aes_pkg;

    localparam int         AES_STATE_W = 128;
    localparam logic [7:0] GF_RED      = 8'h1b;

    typedef logic [1:0] mc_state_t;
    localparam mc_state_t ST_IDLE = 2'd0;
    localparam mc_state_t ST_RUN  = 2'd1;
    localparam mc_state_t ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
    endfunction

    // Only the constants used by the (Inv)MixColumns matrices are supported.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'h01:   res = b;
            8'h02:   res = x2;
            8'h03:   res = x2 ^ b;
            8'h09:   res = x8 ^ b;
            8'h0b:   res = x8 ^ x2 ^ b;
            8'h0d:   res = x8 ^ x4 ^ b;
            8'h0e:   res = x8 ^ x4 ^ x2;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mix_col_unit.sv
// Combinational MixColumns / InvMixColumns for a single 32-bit column (row 0 in
// the top byte).
module mix_col_unit
    import aes_pkg::*;
#(
    parameter int INV_SUPPORT = 1
) (
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    localparam logic [7:0] FWD_C [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] INV_C [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    logic use_inv;
    assign use_inv = (INV_SUPPORT != 0) && inv;

    // Circulant matrix: output row r = sum over k of coef[k] * in[(r+k) mod 4].
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                col_out[31-8*r -: 8] = col_out[31-8*r -: 8]
                    ^ gf_mul(col_in[31-8*((r+k)%4) -: 8], use_inv ? INV_C[k] : FWD_C[k]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns engine: transforms COLS_PER_CYCLE columns per clock
// in place and hands the finished state out over valid/ready.
//
// state   | meaning
// IDLE    | empty, waiting for an input state
// RUN     | working register being transformed one column group per cycle
// DONE    | result presented, waiting for out_ready
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int INV_SUPPORT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int         K        = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(K - 1);

    mc_state_t              state_q;
    logic [1:0]             cnt_q;
    logic [AES_STATE_W-1:0] work_q;
    logic                   inv_q;

    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
        assign col_in[i] = work_q[AES_STATE_W-1-32*(int'(cnt_q)*COLS_PER_CYCLE+i) -: 32];

        mix_col_unit #(
            .INV_SUPPORT(INV_SUPPORT)
        ) u_col (
            .col_in (col_in[i]),
            .inv    (inv_q),
            .col_out(col_out[i])
        );
    end

    // Accepting in DONE only when the result leaves on the same edge removes the IDLE bubble.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign out_state = work_q;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        inv_q   <= in_inv;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        work_q[AES_STATE_W-1-32*(int'(cnt_q)*COLS_PER_CYCLE+i) -: 32] <= col_out[i];
                    end
                    if (cnt_q == LAST_GRP) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            work_q  <= in_state;
                            inv_q   <= in_inv;
                            cnt_q   <= '0;
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1/2/4 columns per cycle, the last
// one forward-only) checked against a polynomial-multiply reference model.
module tb_mix_columns_seq;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   in_inv;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   busy;
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(
            .COLS_PER_CYCLE(1 << g),
            .INV_SUPPORT   ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_state (in_state[g]),
            .in_inv   (in_inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state[g]),
            .busy     (busy[g])
        );
    end

    // Carry-less product followed by long-division reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127-8*(4*c+i) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ ref_mul(base[(j - row + 4) % 4], a[j]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sends one state into an idle instance, waits (bounded) for the result and drains it.
    task automatic transact(input int d, input logic [127:0] st, input logic inv,
                            output logic [127:0] res, output int lat);
        @(negedge clk);
        in_state[d]  = st;
        in_inv[d]    = inv;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_state[d];
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                         d, in_ready[d], out_valid[d], busy[d]);
            end
            n_tests++;
            if (out_state[d] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_out_state dut%0d: got %h want 0", d, out_state[d]);
            end
        end
    endtask

    task automatic test_fips();
        logic [127:0] res;
        int           lat;
        for (int d = 0; d < 3; d++) begin
            transact(d, FIPS_IN, 1'b0, res, lat);
            n_tests++;
            if (res !== FIPS_OUT) begin
                n_fail++;
                $display("FAIL fips_fwd dut%0d: got %h want %h", d, res, FIPS_OUT);
            end
            n_tests++;
            if (lat != (4 >> d)) begin
                n_fail++;
                $display("FAIL fips_latency dut%0d: got %0d want %0d", d, lat, 4 >> d);
            end
            if (d != 2) begin
                transact(d, FIPS_OUT, 1'b1, res, lat);
                n_tests++;
                if (res !== FIPS_IN) begin
                    n_fail++;
                    $display("FAIL fips_inv dut%0d: got %h want %h", d, res, FIPS_IN);
                end
            end else begin
                transact(d, FIPS_IN, 1'b1, res, lat);
                n_tests++;
                if (res !== FIPS_OUT) begin
                    n_fail++;
                    $display("FAIL fwd_only_ignores_inv dut%0d: got %h want %h", d, res, FIPS_OUT);
                end
            end
        end
    endtask

    task automatic test_columns();
        logic [127:0] res;
        logic [127:0] exp_fwd;
        int           lat;
        exp_fwd = 128'h046681e5_8e4da1bc_9fdc589d_01010101;
        transact(0, 128'hd4bf5d30_db135345_f20a225c_01010101, 1'b0, res, lat);
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if (res[127-32*c -: 32] !== exp_fwd[127-32*c -: 32]) begin
                n_fail++;
                $display("FAIL column_fwd col%0d: got %h want %h",
                         c, res[127-32*c -: 32], exp_fwd[127-32*c -: 32]);
            end
        end
        transact(1, {4{32'h01010101}}, 1'b1, res, lat);
        n_tests++;
        if (res !== {4{32'h01010101}}) begin
            n_fail++;
            $display("FAIL identity_inv: got %h want %h", res, {4{32'h01010101}});
        end
        transact(1, exp_fwd, 1'b1, res, lat);
        n_tests++;
        if (res !== 128'hd4bf5d30_db135345_f20a225c_01010101) begin
            n_fail++;
            $display("FAIL column_inv: got %h want d4bf5d30db135345f20a225c01010101", res);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] res;
        int           lat;
        a = rand_state();
        b = rand_state();
        @(negedge clk);
        in_state[0]  = a;
        in_inv[0]    = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_state[0] = b;
        in_inv[0]   = 1'b1;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_state[0] !== ref_mix(a, 1'b0)) begin
                n_fail++;
                $display("FAIL backpressure_hold cyc%0d: valid=%b ready=%b out=%h want 1 0 %h",
                         i, out_valid[0], in_ready[0], out_state[0], ref_mix(a, 1'b0));
            end
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1;
        n_tests++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready: got %b want 1", in_ready[0]);
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        in_inv[0]    = 1'b0;
        n_tests++;
        if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bubble: busy=%b out_valid=%b want 1 0", busy[0], out_valid[0]);
        end
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (lat != 4 || out_state[0] !== ref_mix(b, 1'b1)) begin
            n_fail++;
            $display("FAIL released_state: lat=%0d out=%h want lat 4 out %h", lat, out_state[0], ref_mix(b, 1'b1));
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] st;
        logic [127:0] res;
        int           lat;
        @(negedge clk);
        in_state[0]  = rand_state();
        in_inv[0]    = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_state[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_mid_run: ready=%b valid=%b busy=%b out=%h want 1 0 0 0",
                     in_ready[0], out_valid[0], busy[0], out_state[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        st = rand_state();
        transact(0, st, 1'b1, res, lat);
        n_tests++;
        if (res !== ref_mix(st, 1'b1) || lat != 4) begin
            n_fail++;
            $display("FAIL after_reset: got %h lat %0d want %h lat 4", res, lat, ref_mix(st, 1'b1));
        end
    endtask

    // rnd=0: in_valid/out_ready held high, output spacing must be K+1 cycles.
    task automatic test_stream(input int d, input int n, input bit rnd);
        logic [127:0] q [$];
        logic [127:0] exp_st;
        int           sent;
        int           got;
        int           cyc;
        int           last_out;
        sent = 0;
        got = 0;
        cyc = 0;
        last_out = -1;
        while (got < n && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            out_ready[d] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sent < n) begin
                in_valid[d] = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
                in_state[d] = rand_state();
                in_inv[d]   = 1'($urandom_range(0, 1));
            end else begin
                in_valid[d] = 1'b0;
            end
            #1;
            if (out_valid[d] && out_ready[d]) begin
                exp_st = (q.size() > 0) ? q.pop_front() : 128'hx;
                n_tests++;
                if (out_state[d] !== exp_st) begin
                    n_fail++;
                    $display("FAIL stream dut%0d item%0d: got %h want %h", d, got, out_state[d], exp_st);
                end
                if (!rnd && last_out >= 0) begin
                    n_tests++;
                    if (cyc - last_out != (4 >> d) + 1) begin
                        n_fail++;
                        $display("FAIL throughput dut%0d: spacing %0d want %0d", d, cyc - last_out, (4 >> d) + 1);
                    end
                end
                last_out = cyc;
                got++;
            end
            if (in_valid[d] && in_ready[d]) begin
                q.push_back(ref_mix(in_state[d], in_inv[d] && (d != 2)));
                sent++;
            end
        end
        @(negedge clk);
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        in_inv[d]    = 1'b0;
        n_tests++;
        if (got != n) begin
            n_fail++;
            $display("FAIL stream_count dut%0d: got %0d outputs want %0d", d, got, n);
        end
    endtask

    task automatic test_back_to_back();
        for (int d = 0; d < 3; d++) test_stream(d, 8, 1'b0);
        for (int d = 0; d < 3; d++) test_stream(d, 3334, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) in_state[d] = '0;
        test_reset();
        test_fips();
        test_columns();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
